// File: rtl/brv32p_perf_counters.sv
// Performance-monitor unit: NUM_CNT event counters with a small memory-mapped register port.
// Define BRV32P_PERF_THRESH_EN to build the per-counter THRESH match register.
module brv32p_perf_counters #(
    parameter int NUM_EVENTS = 16,
    parameter int NUM_CNT    = 4,
    parameter int CNT_W      = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_EVENTS-1:0] evt_i,
    input  logic                  bus_valid,
    input  logic                  bus_we,
    input  logic [7:0]            bus_addr,
    input  logic [31:0]           bus_wdata,
    output logic                  bus_rvalid,
    output logic [31:0]           bus_rdata,
    output logic                  irq
);
    localparam int          HW   = CNT_W - 32;
    localparam logic [3:0]  NC4  = 4'(NUM_CNT);
    localparam logic [31:0] INFO = {8'(CNT_W), 8'(NUM_EVENTS), 8'(NUM_CNT), 8'h01};

    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CNT-1:0][HW-1:0]    hi_sh_q, hi_sh_d;
    logic [NUM_CNT-1:0][4:0]       sel_q, sel_d;
    logic [NUM_CNT-1:0]            cen_q, cen_d;
    logic [NUM_CNT-1:0]            ovf_q, ovf_d;
    logic [NUM_CNT-1:0]            irq_en_q, irq_en_d;
    logic                          gen_q, gen_d;
    logic                          irq_q, irq_d;
    logic                          rvalid_q, rvalid_d;
    logic [31:0]                   rdata_q, rdata_d;
`ifdef BRV32P_PERF_THRESH_EN
    logic [NUM_CNT-1:0][31:0]      thr_q, thr_d;
`endif

    logic               wr, rd, glb, cnt_sel, clr, hit;
    logic [3:0]         cidx;
    logic [1:0]         off;
    logic [31:0]        evt_pad;
    logic [NUM_CNT-1:0] ovf_set, ovf_w1c;
    logic [CNT_W-1:0]   nxt;
    logic               unused_addr;

    assign unused_addr = ^bus_addr[1:0];
    assign wr      = bus_valid & bus_we;
    assign rd      = bus_valid & ~bus_we;
    assign off     = bus_addr[3:2];
    assign glb     = (bus_addr[7:4] == 4'd0);
    assign cidx    = bus_addr[7:4] - 4'd2;
    assign cnt_sel = (bus_addr[7:4] >= 4'd2) && (cidx < NC4);
    assign clr     = wr & glb & (off == 2'd0) & bus_wdata[1];
    // Zero-padding makes any select >= NUM_EVENTS see a constant 0 event.
    assign evt_pad = 32'(evt_i);
    assign ovf_w1c = (wr && glb && off == 2'd1) ? bus_wdata[NUM_CNT-1:0] : '0;

    always_comb begin
        cnt_d    = cnt_q;
        hi_sh_d  = hi_sh_q;
        sel_d    = sel_q;
        cen_d    = cen_q;
        irq_en_d = irq_en_q;
        gen_d    = gen_q;
        ovf_set  = '0;
        nxt      = '0;
        hit      = 1'b0;
        rvalid_d = rd;
        rdata_d  = '0;
`ifdef BRV32P_PERF_THRESH_EN
        thr_d    = thr_q;
`endif
        if (wr && glb) begin
            case (off)
                2'd0:    gen_d = bus_wdata[0];
                2'd2:    irq_en_d = bus_wdata[NUM_CNT-1:0];
                default: ;
            endcase
        end
        if (rd && glb) begin
            case (off)
                2'd0:    rdata_d = {31'd0, gen_q};
                2'd1:    rdata_d = 32'(ovf_q);
                2'd2:    rdata_d = 32'(irq_en_q);
                default: rdata_d = INFO;
            endcase
        end
        for (int n = 0; n < NUM_CNT; n++) begin
            hit = cnt_sel && (cidx == 4'(n));
            nxt = cnt_q[n] + CNT_W'(1);
            // A software write to either half wins over this cycle's increment.
            if (wr && hit && off == 2'd1) begin
                cnt_d[n] = {cnt_q[n][CNT_W-1:32], bus_wdata};
            end else if (wr && hit && off == 2'd2) begin
                cnt_d[n] = {bus_wdata[HW-1:0], cnt_q[n][31:0]};
            end else if (gen_q && cen_q[n] && evt_pad[sel_q[n]]) begin
                cnt_d[n]   = nxt;
                ovf_set[n] = (cnt_q[n] == '1);
`ifdef BRV32P_PERF_THRESH_EN
                if (thr_q[n] != 32'd0 && nxt[31:0] == thr_q[n]) ovf_set[n] = 1'b1;
`endif
            end
            if (wr && hit && off == 2'd0) begin
                sel_d[n] = bus_wdata[4:0];
                cen_d[n] = bus_wdata[8];
            end
`ifdef BRV32P_PERF_THRESH_EN
            if (wr && hit && off == 2'd3) thr_d[n] = bus_wdata;
`endif
            if (rd && hit) begin
                case (off)
                    2'd0: rdata_d = {23'd0, cen_q[n], 3'd0, sel_q[n]};
                    2'd1: begin
                        rdata_d    = cnt_q[n][31:0];
                        hi_sh_d[n] = cnt_q[n][CNT_W-1:32];
                    end
                    2'd2: rdata_d = 32'(hi_sh_q[n]);
`ifdef BRV32P_PERF_THRESH_EN
                    default: rdata_d = thr_q[n];
`else
                    default: rdata_d = '0;
`endif
                endcase
            end
        end
        // New overflow beats a same-cycle W1C; clear-all beats both.
        ovf_d = (ovf_q & ~ovf_w1c) | ovf_set;
        if (clr) begin
            cnt_d   = '0;
            hi_sh_d = '0;
            ovf_d   = '0;
        end
        irq_d = |(ovf_q & irq_en_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            hi_sh_q  <= '0;
            sel_q    <= '0;
            cen_q    <= '0;
            ovf_q    <= '0;
            irq_en_q <= '0;
            gen_q    <= 1'b0;
            irq_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
`ifdef BRV32P_PERF_THRESH_EN
            thr_q    <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            hi_sh_q  <= hi_sh_d;
            sel_q    <= sel_d;
            cen_q    <= cen_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            gen_q    <= gen_d;
            irq_q    <= irq_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
`ifdef BRV32P_PERF_THRESH_EN
            thr_q    <= thr_d;
`endif
        end
    end

    assign bus_rvalid = rvalid_q;
    assign bus_rdata  = rdata_q;
    assign irq        = irq_q;
endmodule

// File: tb/tb_brv32p_perf_counters.sv
// Bench for brv32p_perf_counters: directed scenarios plus random traffic, all
// compared every cycle against a register-level behavioural model.
module tb_brv32p_perf_counters;
    localparam int NE = 16;
    localparam int NC = 4;
    localparam int CW = 48;
    localparam logic [63:0] MASK  = (64'd1 << CW) - 64'd1;
    localparam logic [63:0] HMASK = (64'd1 << (CW - 32)) - 64'd1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NE-1:0] evt_i = '0;
    logic          bus_valid = 1'b0;
    logic          bus_we = 1'b0;
    logic [7:0]    bus_addr = '0;
    logic [31:0]   bus_wdata = '0;
    logic          bus_rvalid;
    logic [31:0]   bus_rdata;
    logic          irq;

    brv32p_perf_counters #(.NUM_EVENTS(NE), .NUM_CNT(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .evt_i(evt_i), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // model state
    logic [63:0]   m_cnt [NC];
    logic [63:0]   m_sh  [NC];
    logic [31:0]   m_thr [NC];
    logic [4:0]    m_sel [NC];
    logic          m_cen [NC];
    logic          m_en;
    logic [NC-1:0] m_ovf, m_ien;
    logic          e_rv, e_irq;
    logic [31:0]   e_rd;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] read_reg(input logic [7:0] addr);
        int a, n, o;
        a = int'(addr) & 'hFC;
        if (a < 16) begin
            case (a)
                0:  return {31'd0, m_en};
                4:  return 32'(m_ovf);
                8:  return 32'(m_ien);
                default: return 32'((CW << 24) | (NE << 16) | (NC << 8) | 1);
            endcase
        end
        if (a < 32) return 32'd0;
        n = (a - 32) / 16;
        o = a % 16;
        if (n >= NC) return 32'd0;
        case (o)
            0: return {23'd0, m_cen[n], 3'd0, m_sel[n]};
            4: return m_cnt[n][31:0];
            8: return m_sh[n][31:0];
`ifdef BRV32P_PERF_THRESH_EN
            default: return m_thr[n];
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [63:0]   nc [NC];
        logic [NC-1:0] set;
        logic          wr, inc, is_cnt;
        int            a, n, o;
        if (!rst_n) begin
            for (int k = 0; k < NC; k++) begin
                m_cnt[k] = '0; m_sh[k] = '0; m_thr[k] = '0; m_sel[k] = '0; m_cen[k] = 1'b0;
            end
            m_en = 1'b0; m_ovf = '0; m_ien = '0;
            e_rv = 1'b0; e_rd = '0; e_irq = 1'b0;
            return;
        end
        a = int'(bus_addr) & 'hFC;
        n = (a >= 32) ? (a - 32) / 16 : 0;
        o = a % 16;
        is_cnt = (a >= 32) && (n < NC);
        wr = bus_valid && bus_we;
        e_irq = |(m_ovf & m_ien);
        e_rv = bus_valid && !bus_we;
        e_rd = e_rv ? read_reg(bus_addr) : 32'd0;
        set = '0;
        for (int k = 0; k < NC; k++) begin
            nc[k] = m_cnt[k];
            inc = 1'b0;
            if (int'(m_sel[k]) < NE) inc = m_en && m_cen[k] && evt_i[m_sel[k]];
            if (wr && is_cnt && n == k && o == 4)
                nc[k] = {m_cnt[k][63:32], bus_wdata};
            else if (wr && is_cnt && n == k && o == 8)
                nc[k] = ((64'(bus_wdata) & HMASK) << 32) | (m_cnt[k] & 64'hFFFF_FFFF);
            else if (inc) begin
                nc[k] = (m_cnt[k] + 64'd1) & MASK;
                if (nc[k] == 64'd0) set[k] = 1'b1;
`ifdef BRV32P_PERF_THRESH_EN
                if (m_thr[k] != 32'd0 && nc[k][31:0] == m_thr[k]) set[k] = 1'b1;
`endif
            end
        end
        if (e_rv && is_cnt && o == 4) m_sh[n] = m_cnt[n] >> 32;
        for (int k = 0; k < NC; k++) m_cnt[k] = nc[k];
        if (wr && is_cnt && o == 0) begin
            m_sel[n] = bus_wdata[4:0];
            m_cen[n] = bus_wdata[8];
        end
        if (wr && is_cnt && o == 12) m_thr[n] = bus_wdata;
        if (wr && a == 8) m_ien = bus_wdata[NC-1:0];
        if (wr && a == 4) m_ovf = m_ovf & ~bus_wdata[NC-1:0];
        m_ovf = m_ovf | set;
        if (wr && a == 0) begin
            m_en = bus_wdata[0];
            if (bus_wdata[1]) begin
                for (int k = 0; k < NC; k++) begin m_cnt[k] = '0; m_sh[k] = '0; end
                m_ovf = '0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("rvalid", 32'(bus_rvalid), 32'(e_rv));
        chk("rdata",  bus_rdata, e_rd);
        chk("irq",    32'(irq), 32'(e_irq));
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic wr_reg(input logic [7:0] ad, input logic [31:0] d);
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = ad; bus_wdata = d;
        tick();
        bus_valid = 1'b0; bus_we = 1'b0;
    endtask

    task automatic rd_lit(input logic [7:0] ad, input logic [31:0] exp, input string nm);
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = ad;
        tick();
        bus_valid = 1'b0;
        chk(nm, bus_rdata, exp);
    endtask

    initial begin
        int r, k;
        logic [7:0]  ad;
        logic [31:0] wd;

        // reset
        rst_n = 1'b0;
        ticks(3);
        chk("reset_rvalid", 32'(bus_rvalid), 32'd0);
        chk("reset_rdata", bus_rdata, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        tick();

        rd_lit(8'h0C, 32'h3010_0401, "info");
        for (int i = 0; i < NC; i++) begin
            rd_lit(8'(32 + 16 * i + 4), 32'd0, "reset_lo");
            rd_lit(8'(32 + 16 * i + 8), 32'd0, "reset_hi");
        end

        // 37 events on counter 0
        wr_reg(8'h20, 32'h100);
        wr_reg(8'h00, 32'h1);
        evt_i = 16'h0001;
        ticks(37);
        evt_i = '0;
        rd_lit(8'h24, 32'd37, "count37_lo");
        rd_lit(8'h28, 32'd0, "count37_hi");

        // full-width wrap and irq
        wr_reg(8'h24, 32'hFFFF_FFFF);
        wr_reg(8'h28, 32'h0000_FFFF);
        wr_reg(8'h08, 32'h1);
        evt_i = 16'h0001;
        tick();
        evt_i = '0;
        rd_lit(8'h04, 32'd1, "wrap_ovf");
        chk("wrap_irq_high", 32'(irq), 32'd1);
        rd_lit(8'h24, 32'd0, "wrap_lo");
        wr_reg(8'h04, 32'h1);
        chk("w1c_irq_still", 32'(irq), 32'd1);
        tick();
        chk("w1c_irq_low", 32'(irq), 32'd0);

        // carry into the upper half and coherent HI read
        wr_reg(8'h24, 32'hFFFF_FFFE);
        wr_reg(8'h28, 32'h0);
        evt_i = 16'h0001;
        ticks(3);
        rd_lit(8'h24, 32'd1, "carry_lo");
        rd_lit(8'h28, 32'd1, "carry_hi");
        evt_i = '0;

        // write beats increment, then clear-all
        evt_i = 16'h0001;
        wr_reg(8'h24, 32'h1234);
        evt_i = '0;
        rd_lit(8'h24, 32'h1234, "write_vs_inc");
        evt_i = 16'h0001;
        ticks(5);
        wr_reg(8'h00, 32'h3);
        evt_i = '0;
        rd_lit(8'h24, 32'd0, "clear_lo");
        rd_lit(8'h28, 32'd0, "clear_hi");
        rd_lit(8'h20, 32'h100, "clear_cfg_kept");
        rd_lit(8'h00, 32'd1, "clear_ctrl_kept");

        // select beyond NUM_EVENTS counts nothing; absent counter reads 0
        wr_reg(8'h30, 32'h100 | 32'd20);
        evt_i = '1;
        ticks(5);
        evt_i = '0;
        rd_lit(8'h34, 32'd0, "sel_oob");
        wr_reg(8'h64, 32'hDEAD_BEEF);
        rd_lit(8'h64, 32'd0, "absent_counter");

        // threshold register
        wr_reg(8'h2C, 32'd10);
`ifdef BRV32P_PERF_THRESH_EN
        rd_lit(8'h2C, 32'd10, "thresh_rd");
        wr_reg(8'h00, 32'h3);
        evt_i = 16'h0001;
        ticks(9);
        evt_i = '0;
        rd_lit(8'h04, 32'd0, "thresh_before");
        evt_i = 16'h0001;
        tick();
        evt_i = '0;
        rd_lit(8'h04, 32'd1, "thresh_match");
        wr_reg(8'h2C, 32'd0);
`else
        rd_lit(8'h2C, 32'd0, "thresh_absent");
`endif

        // random traffic
        for (int it = 0; it < 3000; it++) begin
            evt_i = NE'($urandom);
            rst_n = (it != 1500);
            r = $urandom_range(0, 9);
            bus_valid = (r >= 4);
            bus_we = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 15);
            ad = 8'h00;
            wd = $urandom;
            if (k == 0) begin
                ad = 8'h00;
                wd = {30'd0, ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0)};
            end else if (k < 4) begin
                ad = 8'(4 * k);
            end else if (k < 12) begin
                r = $urandom_range(0, 3);
                ad = 8'(32 + 16 * $urandom_range(0, NC - 1) + 4 * r);
                if (r == 0) wd = {23'd0, ($urandom_range(0, 3) != 0), 3'd0, 5'($urandom_range(0, 19))};
                if (r == 1) wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                if (r == 2 && $urandom_range(0, 1) == 1) wd = 32'(HMASK);
            end else begin
                ad = 8'($urandom);
                if (ad[7:2] == 6'd0) wd[1] = 1'b0;
            end
            bus_addr = ad;
            bus_wdata = wd;
            tick();
        end
        bus_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
